// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: FSM state encoding and default width.
// Imported by mont_precompute and its sub-modules.
package rsa_pkg;

    localparam int WIDTH_DEF = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mont_ninv_bitserial.sv
// Bit-serial -N^-1 mod 2^WIDTH: one conditional shifted add per enabled cycle.
// Keeps n*y + 1 == p (mod 2^WIDTH) with p's low idx+1 bits cleared after each step.
module mont_ninv_bitserial
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [IW-1:0]    idx,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] p;

    // Clear bit idx of p by adding n<<idx whenever that bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y <= '0;
            p <= '0;
        end else if (load) begin
            y <= '0;
            p <= WIDTH'(1);
        end else if (en && p[idx]) begin
            y[idx] <= 1'b1;
            p      <= p + (n << idx);
        end
    end

endmodule

// File: rtl/mont_precompute.sv
// Montgomery constant generator: N_INV = -N^-1 mod 2^WIDTH, R2_MOD_N = 2^(2*WIDTH) mod N.
// Optional modulus check compiled in with MONT_PRECOMPUTE_CHECK_EN.
module mont_precompute
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] N_INV,
    output logic [WIDTH-1:0] R2_MOD_N,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH-1:0] y;
    logic             bad;
    logic             accept;
    logic             inv_en;

`ifdef MONT_PRECOMPUTE_CHECK_EN
    assign bad = ~N[0] | (N < WIDTH'(3));
`else
    assign bad = 1'b0;
`endif

    assign accept = (state == ST_IDLE) && start && !bad;
    assign inv_en = (state == ST_RUN) && (cnt < CNT_HALF);
    assign t      = r << 1;
    assign n_ext  = {1'b0, n_q};

    mont_ninv_bitserial #(
        .WIDTH(WIDTH),
        .IW   (IW)
    ) u_ninv (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .en   (inv_en),
        .idx  (cnt[IW-1:0]),
        .n    (n_q),
        .y    (y)
    );

    // Control FSM plus the inline R2 doubling-mod-N track and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            n_q      <= '0;
            r        <= '0;
            N_INV    <= '0;
            R2_MOD_N <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && bad) begin
                        N_INV    <= '0;
                        R2_MOD_N <= '0;
                        err      <= 1'b1;
                        done     <= 1'b1;
                    end else if (accept) begin
                        n_q   <= N;
                        r     <= (WIDTH + 1)'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r   <= (t >= n_ext) ? (t - n_ext) : t;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) state <= ST_DONE;
                end
                ST_DONE: begin
                    N_INV    <= y;
                    R2_MOD_N <= r[WIDTH-1:0];
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    err      <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
